moore_sequence_generator: RTL and testbench
===========================================

Name: moore_sequence_generator

Overview:
- Serial pattern transmitter that drives the bit stream our Moore sequence detectors consume.
- Loads a PAT_W-bit pattern and a repetition count on a start strobe, then shifts the pattern out MSB-first, back-to-back, for the requested number of repetitions.
- Reports busy/done and supports abort.
- Used as stimulus source and as the transmit end of the serial detect link.

Parameters:
- PAT_W, 4, pattern length in bits (min 2).
- CNT_W, 8, width of repetition count.
- DEF_PATTERN, 4'b1101, pattern used when use_default=1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  start request; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE without done.
- use_default  input  1  1 = load DEF_PATTERN, 0 = load pattern_in.
- pattern_in  input  PAT_W  pattern to send, MSB first.
- rep_cnt  input  CNT_W  number of pattern repetitions (0 allowed).
- dout  output  1  serial data bit.
- dout_valid  output  1  dout carries a pattern bit this cycle.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse after the last bit of a completed run.

Behaviour:
- Moore FSM, states IDLE, SHIFT, DONE. All outputs are decoded from registered state and datapath only; no input-to-output combinational path.
- Reset (reset_n=0, any time, including mid-run):
  - state=IDLE; shift reg, bit counter and rep counter cleared.
  - dout=0, dout_valid=0, busy=0, done=0.
- IDLE:
  - Outputs all 0.
  - start=1 at edge k: capture the pattern (DEF_PATTERN or pattern_in) into the shift reg and a hold reg; rep counter=rep_cnt; bit counter=PAT_W-1.
  - If rep_cnt==0, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - dout=shreg[PAT_W-1], dout_valid=1, busy=1.
  - Each edge: shift left by 1, bit counter decrements.
  - When bit counter==0 and rep counter>1: reload shreg from the hold reg, bit counter=PAT_W-1, rep counter decrements. No idle gap between repetitions.
  - When bit counter==0 and rep counter==1: go to DONE.
- DONE: done=1, dout_valid=0, busy=0, dout=0; next edge go to IDLE.
- Latency:
  - start sampled at edge k: first bit valid during cycle k..k+1.
  - Exactly PAT_W*rep_cnt consecutive valid cycles.
  - done high for the single cycle immediately following the last valid bit.
- abort=1 in SHIFT or DONE: next edge go to IDLE; done is not pulsed. abort has priority over start and over every SHIFT transition.
- start while in SHIFT or DONE is ignored; it does not queue.
- start and abort both high in IDLE: abort wins, stay IDLE.
- pattern_in, rep_cnt and use_default changes after capture have no effect on the run in progress.
- rep_cnt at maximum (2^CNT_W-1) must run fully; the counter does not wrap.
- Illegal/unused state encoding: go to IDLE.

Decomposition:
- Shared package seq_pkg:
  - State encodings: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - DEF_PATTERN constant 4'b1101, shared with the detectors.
- Sub-module seq_shift_reg: loadable PAT_W-bit left shifter with a reload-from-hold input. The FSM and counters stay in the top module.

Test Plan:
- Reset then idle: reset_n low mid-cycle -> all outputs 0 immediately (async). Hold start=0 for 10 cycles -> outputs stay 0.
- Default single run: use_default=1, rep_cnt=1, start pulse -> dout_valid high 4 cycles with dout=1,1,0,1, then done=1 for 1 cycle, busy low.
- Back-to-back with overlap check: pattern_in=4'b1101, rep_cnt=3 -> 12 valid bits 110111011101, no gaps. Loop dout into the overlapping 1101 detector -> detector asserts 3 times.
- rep_cnt=0: start -> no dout_valid; done pulses the cycle after start; back to IDLE.
- Abort mid-run: rep_cnt=2, assert abort on the 5th valid bit -> dout_valid low next cycle, done never asserted, new start accepted afterwards.
- Start ignored and reset mid-run: pulse start during SHIFT -> bit count unchanged (PAT_W*rep_cnt). reset_n low during SHIFT -> immediate IDLE, outputs 0, and no done after release.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the detectors that consume its stream.
// State encodings, the default pattern and the grouped output record live here.
package seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Pattern the detectors are built to recognise.
  localparam logic [3:0] DEF_PATTERN = 4'b1101;

  typedef struct packed {
    logic dout;
    logic dout_valid;
    logic busy;
    logic done;
  } seq_out_t;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable PAT_W-bit left shifter. A hold copy of the loaded pattern allows
// seamless reload between repetitions without re-sampling the input pins.
module seq_shift_reg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [PAT_W-1:0] load_val,
  output logic             msb
);

  logic [PAT_W-1:0] shreg;
  logic [PAT_W-1:0] hold;

  // Priority: load over reload over shift; the controller never asserts two at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      hold  <= '0;
    end else if (load) begin
      shreg <= load_val;
      hold  <= load_val;
    end else if (reload) begin
      shreg <= hold;
    end else if (shift) begin
      shreg <= {shreg[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = shreg[PAT_W-1];

endmodule

// File: rtl/moore_sequence_generator.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, back-to-back,
// rep_cnt times, then pulses done. Outputs decode only registered state.
module moore_sequence_generator #(
  parameter int                 PAT_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [PAT_W-1:0]   DEF_PATTERN = PAT_W'(seq_pkg::DEF_PATTERN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             use_default,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] rep_cnt,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  import seq_pkg::*;

  localparam int               BIT_W    = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [BIT_W-1:0] bit_q;
  logic [BIT_W-1:0] bit_nxt;
  logic [CNT_W-1:0] rep_q;
  logic [CNT_W-1:0] rep_nxt;
  logic             sh_load;
  logic             sh_reload;
  logic             sh_shift;
  logic [PAT_W-1:0] load_val;
  logic             msb;
  seq_out_t         obs;

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_q;
    rep_nxt   = rep_q;
    sh_load   = 1'b0;
    sh_reload = 1'b0;
    sh_shift  = 1'b0;
    load_val  = use_default ? DEF_PATTERN : pattern_in;
    case (state)
      ST_IDLE: begin
        // abort beats start even while idle
        if (start && !abort) begin
          sh_load   = 1'b1;
          bit_nxt   = BIT_LAST;
          rep_nxt   = rep_cnt;
          state_nxt = (rep_cnt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (bit_q == '0) begin
          if (rep_q > CNT_W'(1)) begin
            sh_reload = 1'b1;
            bit_nxt   = BIT_LAST;
            rep_nxt   = rep_q - CNT_W'(1);
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          sh_shift = 1'b1;
          bit_nxt  = bit_q - BIT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      bit_q <= '0;
      rep_q <= '0;
    end else begin
      state <= state_nxt;
      bit_q <= bit_nxt;
      rep_q <= rep_nxt;
    end
  end

  seq_shift_reg #(
    .PAT_W (PAT_W)
  ) u_shift (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (sh_load),
    .reload   (sh_reload),
    .shift    (sh_shift),
    .load_val (load_val),
    .msb      (msb)
  );

  always_comb begin
    obs            = '0;
    obs.dout       = (state == ST_SHIFT) & msb;
    obs.dout_valid = (state == ST_SHIFT);
    obs.busy       = (state == ST_SHIFT);
    obs.done       = (state == ST_DONE);
  end

  assign dout       = obs.dout;
  assign dout_valid = obs.dout_valid;
  assign busy       = obs.busy;
  assign done       = obs.done;
  assign dbg_state  = state;

endmodule

// File: tb/tb_moore_sequence_generator.sv
// Bench for moore_sequence_generator: expected output tokens are queued at start time
// and a negedge monitor pops and compares whenever the generator presents output.
module tb_moore_sequence_generator;

  localparam int             PAT_W  = 4;
  localparam int             CNT_W  = 8;
  localparam logic [3:0]     TB_DEF = 4'b1101;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             use_default = 1'b0;
  logic [PAT_W-1:0] pattern_in = '0;
  logic [CNT_W-1:0] rep_cnt = '0;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  // token = {is_done, bit}
  logic [1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [3:0] det_win = '0;
  int         det_len = 0;
  int         det_cnt = 0;

  logic [3:0] mon_out;
  logic [3:0] mon_exp;
  logic [1:0] mon_tok;
  logic       mon_present;
  logic       mon_last_bit = 1'b0;

  moore_sequence_generator #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .use_default (use_default),
    .pattern_in  (pattern_in),
    .rep_cnt     (rep_cnt),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tokens pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      mon_out = {dout, dout_valid, busy, done};
      if (!reset_n) begin
        mon_last_bit = 1'b0;
      end else begin
        mon_present  = (mon_out != 4'b0) || (mon_last_bit && exp_q.size() > 0);
        mon_last_bit = 1'b0;
        if (mon_present) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(mon_out), 32'h0);
          end else begin
            mon_tok = exp_q.pop_front();
            mon_exp = mon_tok[1] ? 4'b0001 : {mon_tok[0], 3'b110};
            check(mon_tok[1] ? "done_pulse" : "stream_bit", 32'(mon_out), 32'(mon_exp));
            mon_last_bit = !mon_tok[1];
          end
        end
        if (dout_valid) begin
          det_win = {det_win[2:0], dout};
          det_len++;
          if (det_len >= 4 && det_win == 4'b1101) det_cnt++;
        end
      end
    end
  end

  task automatic drain(input int budget);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < budget) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
  endtask

  // Reference model: pattern bits MSB-first, reps times, then done; truncated on abort/reset.
  task automatic run(input bit ud, input logic [3:0] pat, input int reps,
                     input int abort_at, input int reset_at, input bit restart);
    logic [3:0] p;
    int total;
    int keep;
    int n;
    p     = ud ? TB_DEF : pat;
    total = PAT_W * reps;
    keep  = total;
    if (abort_at >= 0) keep = abort_at + 1;
    if (reset_at >= 0) keep = reset_at;
    @(posedge clk);
    #1;
    n = 0;
    for (int r = 0; r < reps; r++) begin
      for (int i = PAT_W - 1; i >= 0; i--) begin
        if (n < keep) exp_q.push_back({1'b0, p[i]});
        n++;
      end
    end
    if (abort_at < 0 && reset_at < 0) exp_q.push_back(2'b10);
    use_default = ud;
    pattern_in  = pat;
    rep_cnt     = reps[CNT_W-1:0];
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    use_default = 1'($urandom);
    pattern_in  = 4'($urandom);
    rep_cnt     = 8'($urandom);
    check("first_cycle", 32'({dout_valid, done}), (reps == 0) ? 32'h1 : 32'h2);
    if (restart) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (abort_at >= 0) begin
      repeat (abort_at) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_exit", 32'({dout_valid, busy, done}), 32'h0);
    end
    if (reset_at >= 0) begin
      repeat (reset_at) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("reset_midrun", 32'({dout, dout_valid, busy, done, dbg_state}), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
    end
    drain(total + 20);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // stimulus
  initial begin
    #7;
    check("reset_state", 32'({dout, dout_valid, busy, done, dbg_state}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", 32'({dout, dout_valid, busy, done}), 32'h0);
    end

    run(1'b1, 4'h0, 1, -1, -1, 1'b0);

    det_cnt = 0;
    det_len = 0;
    run(1'b0, 4'b1101, 3, -1, -1, 1'b0);
    check("detector_hits", 32'(det_cnt), 32'd3);

    run(1'b0, 4'b1010, 0, -1, -1, 1'b0);

    run(1'b0, 4'b0110, 2, 4, -1, 1'b0);
    run(1'b0, 4'b1001, 1, -1, -1, 1'b0);

    run(1'b0, 4'b1001, 3, -1, -1, 1'b1);

    run(1'b0, 4'b1011, 2, -1, 2, 1'b0);
    run(1'b1, 4'h0, 2, -1, -1, 1'b0);

    start       = 1'b1;
    abort       = 1'b1;
    use_default = 1'b1;
    rep_cnt     = 8'd3;
    @(posedge clk);
    #1;
    check("idle_abort_wins", 32'({dout, dout_valid, busy, done, dbg_state}), 32'h0);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    run(1'b0, 4'($urandom), 255, -1, -1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          int'($urandom_range(0, 5)), -1, -1, 1'($urandom_range(0, 1)) && 1'b0);
    end

    for (int k = 0; k < 4; k++) begin
      run(1'b0, 4'($urandom_range(0, 15)), int'($urandom_range(1, 4)),
          int'($urandom_range(0, 3)), -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
